// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte out. Completion is marked by a single-cycle rx_done_tick.
// There is no backpressure: a consumer must take dout in the cycle rx_done_tick is high.
interface uart_rx_if;
   logic       rx;
   logic       s_tick;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       frame_err;

   modport master (output rx, s_tick, input dout, rx_done_tick, frame_err);
   modport slave  (input rx, s_tick, output dout, rx_done_tick, frame_err);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pins. Latency is 2 clk. It has no handshake.
// Reset loads RST_VAL, which is all ones by default, so an idle-high line does not look active after reset.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// This is an 8N1 UART receiver using 16x s_tick oversampling. It samples mid-bit and flags framing errors and breaks.
// rx_done_tick is asserted 1 clk after the s_tick at mid-stop-bit. There is no backpressure, so each byte is valid for only that cycle.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic     clk,
   input  logic     reset,
   uart_rx_if.slave bus
);
   localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

   state_t        state, state_nx;
   logic [SW-1:0] s, s_nx;
   logic [2:0]    n, n_nx;
   logic [7:0]    b, b_nx;
   logic [7:0]    dout, dout_nx;
   logic          done, done_nx;
   logic          ferr, ferr_nx;
   logic          rx_s;
   logic          tick;

   sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.rx),
      .q     (rx_s)
   );

   assign tick = bus.s_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         s     <= '0;
         n     <= '0;
         b     <= '0;
         dout  <= '0;
         done  <= 1'b0;
         ferr  <= 1'b0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         n     <= n_nx;
         b     <= b_nx;
         dout  <= dout_nx;
         done  <= done_nx;
         ferr  <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      s_nx     = s;
      n_nx     = n;
      b_nx     = b;
      dout_nx  = dout;
      ferr_nx  = ferr;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_nx = START;
               s_nx     = '0;
            end
         end
         START: begin
            // A start bit that is no longer low at its midpoint is treated as a glitch.
            if (tick) begin
               if (s == SW'(MID_TICK)) begin
                  if (!rx_s) begin
                     state_nx = DATA;
                     s_nx     = '0;
                     n_nx     = '0;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s == SW'(OVERSAMPLE - 1)) begin
                  b_nx = {rx_s, b[7:1]};
                  s_nx = '0;
                  if (n == 3'(DBIT - 1)) state_nx = STOP;
                  else                   n_nx     = n + 1'b1;
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (s == SW'(SB_TICK - 1)) begin
                  dout_nx  = b >> (8 - DBIT);
                  ferr_nx  = ~rx_s;
                  done_nx  = 1'b1;
                  s_nx     = '0;
                  state_nx = rx_s ? IDLE : BRK;
               end else begin
                  s_nx = s + 1'b1;
               end
            end
         end
         BRK: begin
            if (rx_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.dout         = dout;
   assign bus.rx_done_tick = done;
   assign bus.frame_err    = ferr;
endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed frames are sent to 8-bit and 7-bit receivers.
// A queue of expected bytes is built from the frame contents and compared on every rx_done_tick.
module tb_uart_rx;
   localparam int TICK_DIV = 27;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
   } exp_t;

   logic clk    = 1'b0;
   logic reset  = 1'b1;
   logic s_tick = 1'b0;
   logic rx8    = 1'b1;
   logic rx7    = 1'b1;
   int   tick_cnt = 0;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   done8 = 0, done7 = 0;
   int   pushed8 = 0, pushed7 = 0;
   logic prev8 = 1'b0, prev7 = 1'b0;
   exp_t q8[$];
   exp_t q7[$];

   uart_rx_if bus8();
   uart_rx_if bus7();
   assign bus8.rx     = rx8;
   assign bus8.s_tick = s_tick;
   assign bus7.rx     = rx7;
   assign bus7.s_tick = s_tick;

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
   uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (.clk(clk), .reset(reset), .bus(bus7));

   always #10 clk = ~clk;

   always @(negedge clk) begin
      tick_cnt = (tick_cnt == TICK_DIV - 1) ? 0 : tick_cnt + 1;
      s_tick   = (tick_cnt == 0);
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus8.rx_done_tick) begin
         done8++;
         check("done8_width", 32'(prev8), 32'h0);
         check("done8_pending", 32'(q8.size() != 0), 32'h1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check("done8_dout", 32'(bus8.dout), 32'(e.d));
            check("done8_ferr", 32'(bus8.frame_err), 32'(e.fe));
         end
      end
      prev8 = bus8.rx_done_tick;
      if (bus7.rx_done_tick) begin
         done7++;
         check("done7_width", 32'(prev7), 32'h0);
         check("done7_pending", 32'(q7.size() != 0), 32'h1);
         if (q7.size() != 0) begin
            e = q7.pop_front();
            check("done7_dout", 32'(bus7.dout), 32'(e.d));
            check("done7_ferr", 32'(bus7.frame_err), 32'(e.fe));
         end
      end
      prev7 = bus7.rx_done_tick;
   end

   task automatic wait_ticks(int k);
      int c = 0;
      while (c < k) begin
         @(posedge clk);
         if (s_tick) c++;
      end
   endtask

   task automatic set_line(int line, logic v);
      @(negedge clk);
      if (line == 7) rx7 = v;
      else           rx8 = v;
   endtask

   task automatic send_bit(int line, logic v, int k);
      set_line(line, v);
      wait_ticks(k);
   endtask

   task automatic push_exp(int line, logic [7:0] d, logic fe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      if (line == 7) begin q7.push_back(e); pushed7++; end
      else           begin q8.push_back(e); pushed8++; end
   endtask

   // Expected byte: the data bits that were sent, placed LSB first; frame_err is the inverse of the stop bit.
   task automatic send_frame(int line, logic [7:0] data, int nbits, logic stop_v, int gap);
      logic [7:0] m;
      m = 8'((1 << nbits) - 1);
      push_exp(line, data & m, ~stop_v);
      send_bit(line, 1'b0, 16);
      for (int i = 0; i < nbits; i++) send_bit(line, data[i], 16);
      send_bit(line, stop_v, 16);
      if (gap > 0) send_bit(line, 1'b1, gap);
   endtask

   task automatic rand_frames(int line, int nbits, int count);
      logic [7:0] d;
      logic       sv;
      for (int i = 0; i < count; i++) begin
         d  = 8'($urandom_range(0, 255));
         sv = ($urandom_range(0, 3) != 0);
         send_frame(line, d, nbits, sv, sv ? int'($urandom_range(0, 24)) : int'($urandom_range(16, 32)));
      end
   endtask

   initial begin
      #2500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         c;
      logic [7:0] v77;
      v77 = 8'h77;

      repeat (4) @(negedge clk);
      check("rst_dout8", 32'(bus8.dout), 32'h0);
      check("rst_done8", 32'(bus8.rx_done_tick), 32'h0);
      check("rst_ferr8", 32'(bus8.frame_err), 32'h0);
      check("rst_dout7", 32'(bus7.dout), 32'h0);
      reset = 1'b0;
      wait_ticks(32);

      send_frame(8, 8'hA5, 8, 1'b1, 16);
      check("a5_count", 32'(done8), 32'h1);
      check("a5_dout", 32'(bus8.dout), 32'hA5);

      c = done8;
      send_bit(8, 1'b0, 4);
      send_bit(8, 1'b1, 32);
      check("glitch_no_done", 32'(done8), 32'(c));
      check("glitch_dout", 32'(bus8.dout), 32'hA5);

      send_frame(8, 8'h3C, 8, 1'b0, 16);
      check("stoplow_ferr_held", 32'(bus8.frame_err), 32'h1);
      check("stoplow_dout", 32'(bus8.dout), 32'h3C);

      c = done8;
      push_exp(8, 8'h00, 1'b1);
      send_bit(8, 1'b0, 16 * 20);
      send_bit(8, 1'b1, 16);
      check("brk_one_done", 32'(done8 - c), 32'h1);
      send_frame(8, 8'h55, 8, 1'b1, 16);
      check("after_brk_dout", 32'(bus8.dout), 32'h55);
      check("after_brk_ferr", 32'(bus8.frame_err), 32'h0);

      c = done8;
      send_frame(8, 8'h00, 8, 1'b1, 0);
      send_frame(8, 8'hFF, 8, 1'b1, 0);
      send_frame(8, 8'h81, 8, 1'b1, 16);
      check("b2b_count", 32'(done8 - c), 32'h3);

      // Abort 0x77 in the middle of data bit 4; the line then returns to idle.
      c = done8;
      send_bit(8, 1'b0, 16);
      for (int i = 0; i < 4; i++) send_bit(8, v77[i], 16);
      send_bit(8, v77[4], 8);
      @(negedge clk) reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check("midrst_dout", 32'(bus8.dout), 32'h0);
      check("midrst_ferr", 32'(bus8.frame_err), 32'h0);
      send_bit(8, 1'b1, 40);
      check("midrst_no_done", 32'(done8), 32'(c));
      send_frame(8, 8'h12, 8, 1'b1, 16);
      check("midrst_then_count", 32'(done8 - c), 32'h1);
      check("midrst_then_dout", 32'(bus8.dout), 32'h12);

      fork
         rand_frames(8, 8, 3);
         begin
            send_frame(7, 8'h5A, 7, 1'b1, 8);
            check("d7_dout", 32'(bus7.dout), 32'h5A);
            check("d7_msb", 32'(bus7.dout[7]), 32'h0);
            rand_frames(7, 7, 3);
         end
      join

      wait_ticks(48);
      check("q8_drained", 32'(q8.size()), 32'h0);
      check("q7_drained", 32'(q7.size()), 32'h0);
      check("done8_total", 32'(done8), 32'(pushed8));
      check("done7_total", 32'(done7), 32'(pushed7));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
